weed_path_planner: RTL and testbench

- Parametrised successor to the single-row weed-bot motion sequencer.
- Drives a serpentine (boustrophedon) coverage of a field NUM_ROWS rows by ROW_STEPS steps. It alternates right/left turns between rows, pauses on plant detection with a programmable dwell, and signals completion.
- Sits between the plant-detect front end and the motor command drivers. Issues one motion command per tick period.

---
 rtl/weed_intel_pkg.sv | 34 +++
 rtl/weed_path_planner_if.sv | 45 ++++
 rtl/weed_tick_gen.sv | 36 +++
 rtl/weed_path_planner.sv | 177 +++++++++++++++++
 tb/tb_weed_path_planner.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weed_intel_pkg.sv
// Shared types and helpers for the serpentine weed path planner.
//   planner_state_e : planner FSM states
//   pending_act_e   : action resumed after a plant stop
//   motion_cmd_t    : registered command bundle driven to the motor drivers
//   idx_width()     : max(1, clog2(n)) width helper
package weed_intel_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FORWARD = 3'd1,
        S_TURN    = 3'd2,
        S_STOP    = 3'd3,
        S_DONE    = 3'd4
    } planner_state_e;

    typedef enum logic {
        ACT_FWD  = 1'b0,
        ACT_TURN = 1'b1
    } pending_act_e;

    typedef struct packed {
        logic front;
        logic right;
        logic left;
        logic stop;
        logic done;
    } motion_cmd_t;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/weed_path_planner_if.sv
// Planner command/status bundle between detect front end, planner and motor drivers.
//   start, plant                 : requests into the planner
//   front/right/left/stop/done   : registered motion commands and status
//   row_index, step_index        : current row and forward steps issued in it
//   plant_events (WEED_PLANT_COUNT_EN only) : saturating count of plant stops
// Modports: master = requester/observer side, slave = planner side.
interface weed_path_planner_if #(
    parameter int unsigned ROW_W  = 3,
    parameter int unsigned STEP_W = 3
);

    logic              start;
    logic              plant;
    logic              front;
    logic              right;
    logic              left;
    logic              stop;
    logic              done;
    logic [ROW_W-1:0]  row_index;
    logic [STEP_W-1:0] step_index;
`ifdef WEED_PLANT_COUNT_EN
    logic [15:0]       plant_events;

    modport master (
        output start, plant,
        input  front, right, left, stop, done, row_index, step_index, plant_events
    );

    modport slave (
        input  start, plant,
        output front, right, left, stop, done, row_index, step_index, plant_events
    );
`else
    modport master (
        output start, plant,
        input  front, right, left, stop, done, row_index, step_index
    );

    modport slave (
        input  start, plant,
        output front, right, left, stop, done, row_index, step_index
    );
`endif

endinterface

// File: rtl/weed_tick_gen.sv
// Motion tick generator: counts 0..TICK_CYCLES-1 while running and flags the last count.
//   clock, reset_n : clock and asynchronous active-low reset
//   i_run          : counter advances only while asserted
//   i_clear        : synchronous clear, aligns the first tick to TICK_CYCLES after start
//   o_tick_c       : one-cycle tick (combinational decode of the count)
module weed_tick_gen
    import weed_intel_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 15_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick_c
);

    localparam int unsigned         CNT_W   = idx_width(TICK_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Wrapping period counter, frozen while not running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == CNT_MAX) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_tick_c = i_run && (r_count == CNT_MAX);

endmodule

// File: rtl/weed_path_planner.sv
// Serpentine field-coverage planner: one motion command per tick, right/left turns
// alternating between rows, plant stops with a plant-free dwell, then done.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : start/plant in; front/right/left/stop/done, row_index, step_index out
// Optional feature macro WEED_PLANT_COUNT_EN adds bus.plant_events, a saturating
// 16-bit count of STOP entries cleared by reset and by an accepted start.
// step_index is sized to hold ROW_STEPS itself, since a complete row reports it.
module weed_path_planner
    import weed_intel_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 15_000_000,
    parameter int unsigned ROW_STEPS   = 4,
    parameter int unsigned NUM_ROWS    = 8,
    parameter int unsigned DWELL_TICKS = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    weed_path_planner_if.slave bus
);

    localparam int unsigned         ROW_W      = idx_width(NUM_ROWS);
    localparam int unsigned         STEP_W     = idx_width(ROW_STEPS + 1);
    localparam int unsigned         DWELL_W    = idx_width(DWELL_TICKS + 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(ROW_STEPS);
    localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(NUM_ROWS - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LOAD = DWELL_W'(DWELL_TICKS);

    planner_state_e     r_state,   w_state_n;
    logic [ROW_W-1:0]   r_row,     w_row_n;
    logic [STEP_W-1:0]  r_step,    w_step_n;
    logic [DWELL_W-1:0] r_dwell,   w_dwell_n;
    pending_act_e       r_pend,    w_pend_n;
    motion_cmd_t        r_cmd,     w_cmd_n;

    logic               w_tick;
    logic               w_run;
    logic               w_accept;
    logic               w_do_act;
    pending_act_e       w_act;
    pending_act_e       w_row_act;

    assign w_run     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_row_act = (r_step < STEP_LAST) ? ACT_FWD : ACT_TURN;

    weed_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_run    (w_run),
        .i_clear  (w_accept),
        .o_tick_c (w_tick)
    );

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_pend  <= ACT_FWD;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_n;
            r_row   <= w_row_n;
            r_step  <= w_step_n;
            r_dwell <= w_dwell_n;
            r_pend  <= w_pend_n;
            r_cmd   <= w_cmd_n;
        end
    end

    // Next-state and command decode; everything past IDLE/DONE moves on ticks only.
    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_step_n  = r_step;
        w_dwell_n = r_dwell;
        w_pend_n  = r_pend;
        w_cmd_n   = r_cmd;
        w_accept  = 1'b0;
        w_do_act  = 1'b0;
        w_act     = r_pend;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept  = 1'b1;
                    w_state_n = S_FORWARD;
                    w_row_n   = '0;
                    w_step_n  = '0;
                    w_dwell_n = '0;
                    w_cmd_n   = '0;
                end
            end
            S_FORWARD, S_TURN: begin
                if (w_tick) begin
                    if (bus.plant) begin
                        w_state_n    = S_STOP;
                        w_pend_n     = w_row_act;
                        w_dwell_n    = DWELL_LOAD;
                        w_cmd_n      = '0;
                        w_cmd_n.stop = 1'b1;
                    end else begin
                        w_do_act = 1'b1;
                        w_act    = w_row_act;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (bus.plant) begin
                        w_dwell_n = DWELL_LOAD;
                    end else if (r_dwell != '0) begin
                        w_dwell_n = r_dwell - DWELL_W'(1);
                    end else begin
                        w_do_act = 1'b1;
                        w_act    = r_pend;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Execute a forward step, a row turn, or finish when the last row is complete.
        if (w_do_act) begin
            w_cmd_n = '0;
            if (w_act == ACT_FWD) begin
                w_cmd_n.front = 1'b1;
                w_step_n      = r_step + STEP_W'(1);
                w_state_n     = S_FORWARD;
            end else if (r_row < ROW_LAST) begin
                w_cmd_n.right = ~r_row[0];
                w_cmd_n.left  = r_row[0];
                w_row_n       = r_row + ROW_W'(1);
                w_step_n      = '0;
                w_state_n     = S_TURN;
            end else begin
                w_cmd_n.done  = 1'b1;
                w_state_n     = S_DONE;
            end
        end
    end

    assign bus.front      = r_cmd.front;
    assign bus.right      = r_cmd.right;
    assign bus.left       = r_cmd.left;
    assign bus.stop       = r_cmd.stop;
    assign bus.done       = r_cmd.done;
    assign bus.row_index  = r_row;
    assign bus.step_index = r_step;

`ifdef WEED_PLANT_COUNT_EN
    logic        w_stop_entry;
    logic [15:0] r_events;

    assign w_stop_entry = w_tick && bus.plant &&
                          ((r_state == S_FORWARD) || (r_state == S_TURN));

    // Saturating count of plant stops since the last accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_events <= '0;
        end else if (w_accept) begin
            r_events <= '0;
        end else if (w_stop_entry && (r_events != 16'hFFFF)) begin
            r_events <= r_events + 16'd1;
        end
    end

    assign bus.plant_events = r_events;
`endif

endmodule

// File: tb/tb_weed_path_planner.sv
// Bench for weed_path_planner: directed scenarios with literal expectations plus
// randomized plant/start traffic, all checked each cycle against a tick-level model.
module tb_weed_path_planner;
    import weed_intel_pkg::*;

    localparam int unsigned TICK_CYCLES = 4;
    localparam int unsigned ROW_STEPS   = 2;
    localparam int unsigned NUM_ROWS    = 3;
    localparam int unsigned DWELL_TICKS = 1;
    localparam int unsigned ROW_W       = idx_width(NUM_ROWS);
    localparam int unsigned STEP_W      = idx_width(ROW_STEPS + 1);
    localparam int          ROW_LEN     = ROW_STEPS + 1;
    localparam int          N_ACT       = NUM_ROWS * ROW_LEN - 1;

    // {front, right, left, stop, done}
    localparam logic [4:0] O_0 = 5'b00000;
    localparam logic [4:0] O_F = 5'b10000;
    localparam logic [4:0] O_R = 5'b01000;
    localparam logic [4:0] O_L = 5'b00100;
    localparam logic [4:0] O_S = 5'b00010;
    localparam logic [4:0] O_D = 5'b00001;

    localparam logic [4:0] T2_OUT  [0:8] = '{O_F, O_F, O_R, O_F, O_F, O_L, O_F, O_F, O_D};
    localparam int         T2_ROW  [0:8] = '{0, 0, 1, 1, 1, 2, 2, 2, 2};
    localparam int         T2_STEP [0:8] = '{1, 2, 0, 1, 2, 0, 1, 2, 2};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    weed_path_planner_if #(.ROW_W(ROW_W), .STEP_W(STEP_W)) bus ();

    weed_path_planner #(
        .TICK_CYCLES (TICK_CYCLES),
        .ROW_STEPS   (ROW_STEPS),
        .NUM_ROWS    (NUM_ROWS),
        .DWELL_TICKS (DWELL_TICKS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model (tick level) ----------------
    // Coverage is a fixed list of N_ACT actions; m_p is how many have executed.
    bit         m_active  = 1'b0;
    bit         m_stopped = 1'b0;
    int         m_dwell   = 0;
    int         m_p       = 0;
    int         m_cnt     = 0;
    int         m_events  = 0;
    logic [4:0] m_out     = O_0;

    function automatic logic [4:0] act_out(input int p);
        if ((p % ROW_LEN) < ROW_STEPS) return O_F;
        return (((p / ROW_LEN) % 2) == 0) ? O_R : O_L;
    endfunction

    task automatic model_exec();
        if (m_p >= N_ACT) begin
            m_out    = O_D;
            m_active = 1'b0;
        end else begin
            m_out = act_out(m_p);
            m_p   = m_p + 1;
        end
    endtask

    task automatic model_tick(input logic pl);
        if (m_stopped) begin
            if (pl) begin
                m_dwell = DWELL_TICKS;
            end else if (m_dwell > 0) begin
                m_dwell = m_dwell - 1;
            end else begin
                m_stopped = 1'b0;
                model_exec();
            end
        end else if (pl) begin
            m_stopped = 1'b1;
            m_dwell   = DWELL_TICKS;
            m_out     = O_S;
            if (m_events < 65535) m_events = m_events + 1;
        end else begin
            model_exec();
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active  = 1'b0;
            m_stopped = 1'b0;
            m_dwell   = 0;
            m_p       = 0;
            m_cnt     = 0;
            m_events  = 0;
            m_out     = O_0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active  = 1'b1;
                m_stopped = 1'b0;
                m_dwell   = 0;
                m_p       = 0;
                m_cnt     = 0;
                m_events  = 0;
                m_out     = O_0;
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == TICK_CYCLES) begin
                m_cnt = 0;
                model_tick(bus.plant);
            end
        end
    end

    // ---------------- compare process ----------------
    string      lit_name = "";
    logic [4:0] lit_out  = O_0;
    int         lit_row  = 0;
    int         lit_step = 0;
    int         lit_evt  = 0;
    int         lit_seq  = 0;
    int         lit_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [4:0] dut_o;
        dut_o = {bus.front, bus.right, bus.left, bus.stop, bus.done};
        chk("model outputs", int'(dut_o), int'(m_out));
        chk("model row_index", int'(bus.row_index), m_p / ROW_LEN);
        chk("model step_index", int'(bus.step_index), m_p % ROW_LEN);
`ifdef WEED_PLANT_COUNT_EN
        chk("model plant_events", int'(bus.plant_events), m_events);
`endif
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            chk({lit_name, " outputs"}, int'(dut_o), int'(lit_out));
            chk({lit_name, " row_index"}, int'(bus.row_index), lit_row);
            chk({lit_name, " step_index"}, int'(bus.step_index), lit_step);
`ifdef WEED_PLANT_COUNT_EN
            chk({lit_name, " plant_events"}, int'(bus.plant_events), lit_evt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    int ph = 0;

    task automatic expect_lit(input string nm, input logic [4:0] o, input int r,
                              input int s, input int e);
        lit_name = nm;
        lit_out  = o;
        lit_row  = r;
        lit_step = s;
        lit_evt  = e;
        lit_seq  = lit_seq + 1;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        ph = ph + 1;
    endtask

    task automatic adv(input int p);
        while (ph < p) step();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ph = 0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.plant = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-count, then no ticks without start.
        do_start();
        expect_lit("pre_tick", O_0, 0, 0, 0);
        adv(8);
        expect_lit("t2_fwd", O_F, 0, 2, 0);
        adv(9);
        reset_n = 1'b0;
        expect_lit("async_rst", O_0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        repeat (12) step();
        expect_lit("idle_no_tick", O_0, 0, 0, 0);

        // Plant-free full run.
        do_start();
        for (int k = 1; k <= 9; k++) begin
            adv(4 * k);
            expect_lit($sformatf("run_t%0d", k), T2_OUT[k-1], T2_ROW[k-1], T2_STEP[k-1], 0);
        end
        adv(44);
        expect_lit("done_hold", O_D, 2, 2, 0);

        // Single plant at tick 2 with a forward step pending.
        do_start();
        expect_lit("restart", O_0, 0, 0, 0);
        adv(4);
        bus.plant = 1'b1;
        adv(8);
        bus.plant = 1'b0;
        expect_lit("p_t2_stop", O_S, 0, 1, 1);
        adv(12);
        expect_lit("p_t3_dwell", O_S, 0, 1, 1);
        adv(16);
        expect_lit("p_t4_fwd", O_F, 0, 2, 1);
        adv(20);
        expect_lit("p_t5_right", O_R, 1, 0, 1);
        adv(44);
        expect_lit("p_t11_done", O_D, 2, 2, 1);

        // Plant at ticks 3-5 with a turn pending.
        do_start();
        adv(8);
        bus.plant = 1'b1;
        expect_lit("q_t2_fwd", O_F, 0, 2, 0);
        adv(12);
        expect_lit("q_t3_stop", O_S, 0, 2, 1);
        adv(20);
        bus.plant = 1'b0;
        expect_lit("q_t5_stop", O_S, 0, 2, 1);
        adv(24);
        expect_lit("q_t6_stop", O_S, 0, 2, 1);
        adv(28);
        expect_lit("q_t7_right", O_R, 1, 0, 1);
        adv(52);
        expect_lit("q_t13_done", O_D, 2, 2, 1);

        // Start while busy is ignored; start in DONE restarts.
        do_start();
        expect_lit("restart_clr", O_0, 0, 0, 0);
        adv(15);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_lit("busy_start_t4", O_F, 1, 1, 0);
        adv(20);
        expect_lit("busy_t5", O_F, 1, 2, 0);
        adv(36);
        expect_lit("busy_t9_done", O_D, 2, 2, 0);

        // Reset during STOP on row 1.
        do_start();
        adv(12);
        bus.plant = 1'b1;
        expect_lit("r_t3_right", O_R, 1, 0, 0);
        adv(16);
        expect_lit("r_t4_stop", O_S, 1, 0, 1);
        adv(17);
        reset_n   = 1'b0;
        bus.plant = 1'b0;
        expect_lit("rst_in_stop", O_0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        step();
        do_start();
        adv(4);
        expect_lit("after_rst_t1", O_F, 0, 1, 0);

        // Random plant levels and occasional start pulses.
        for (int i = 0; i < 3000; i++) begin
            bus.plant = ($urandom_range(0, 3) == 0);
            bus.start = ($urandom_range(0, 59) == 0);
            step();
        end
        bus.start = 1'b0;
        bus.plant = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
